// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache_wt write-through data cache: FSM encoding,
// write-size codes and line geometry.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WDONE = 2'd3
  } state_t;

  localparam logic [1:0] WSIZE_WORD   = 2'd0;
  localparam logic [1:0] WSIZE_BYTE   = 2'd1;
  localparam logic [1:0] WSIZE_HALF   = 2'd2;
  localparam logic [1:0] WSIZE_TRIPLE = 2'd3;

  localparam int LINE_WORDS = 4;

  // Number of store bytes encoded by a write-size code (code 0 is a full word).
  function automatic logic [2:0] wsize_bytes(input logic [1:0] ws);
    return (ws == WSIZE_WORD) ? 3'd4 : {1'b0, ws};
  endfunction

endpackage

// File: rtl/dcache_byte_merge.sv
// Big-endian store lane placement: right-justified store data is spread over the
// bytes starting at the address offset, clipped at the word boundary.
module dcache_byte_merge
  import dcache_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_wsize,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane,
  output logic [31:0] o_merged
);

  logic [2:0] w_n;
  logic [2:0] w_pos;
  logic [1:0] w_src;

  // Byte lane b (bits [31-8b -: 8]) takes source byte n-1-(b-offset); b<offset wraps above 4.
  always_comb begin
    w_n      = wsize_bytes(i_wsize);
    w_pos    = 3'd0;
    w_src    = 2'd0;
    o_be     = 4'b0000;
    o_lane   = 32'h0000_0000;
    o_merged = i_old;
    for (int b = 0; b < 4; b++) begin
      w_pos = 3'(b) - {1'b0, i_offset};
      if (w_pos < w_n) begin
        w_src                   = 2'(w_n - 3'd1 - w_pos);
        o_be[3-b]               = 1'b1;
        o_lane[8*(3-b) +: 8]    = i_wdata[8*w_src +: 8];
        o_merged[8*(3-b) +: 8]  = i_wdata[8*w_src +: 8];
      end else begin
        o_merged[8*(3-b) +: 8]  = i_old[8*(3-b) +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with 4-word line refill.
// Define DCACHE_STATS_EN to add saturating hit/miss/write counters.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  wsize_in,
  input  logic        rd_in,
  input  logic        wr_in,
  output logic [31:0] rdata_out,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] write_count
`endif
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 4;
  localparam int LINES    = 1 << INDEX_BITS;

  logic [31:0]         r_data [LINES][LINE_WORDS];
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [LINES-1:0]    r_valid;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_beat;

  logic [1:0]            w_word;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_hit;
  logic                  w_stall;
  logic [3:0]            w_be;
  logic [31:0]           w_lane;
  logic [31:0]           w_merged;

  assign w_word  = addr_in[3:2];
  assign w_index = addr_in[INDEX_BITS+3:4];
  assign w_tag   = addr_in[31:INDEX_BITS+4];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

  dcache_byte_merge u_merge (
    .i_offset (addr_in[1:0]),
    .i_wsize  (wsize_in),
    .i_wdata  (wdata_in),
    .i_old    (r_data[w_index][w_word]),
    .o_be     (w_be),
    .o_lane   (w_lane),
    .o_merged (w_merged)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode plus the combinational stall and hit data.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    rdata_out   = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        if (wr_in) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_WRITE;
        end else if (rd_in) begin
          if (w_hit) begin
            rdata_out = r_data[w_index][w_word];
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        w_stall = 1'b1;
        if (mem_ack && (r_beat == 2'd3)) w_state_nxt = ST_IDLE;
        else                             w_state_nxt = ST_FILL;
      end
      ST_WRITE: begin
        w_stall = 1'b1;
        if (mem_ack) w_state_nxt = ST_WDONE;
        else         w_state_nxt = ST_WRITE;
      end
      ST_WDONE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall is forced low while reset is held so the pipeline is released at once.
  assign stall_out = w_stall & RESET;

  // Backing-memory request registers, beat counter and valid bits.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid   <= '0;
      r_beat    <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wr_in) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr_in[31:2], 2'b00};
            mem_wdata <= w_lane;
            mem_be    <= w_be;
          end else if (rd_in && !w_hit) begin
            r_valid[w_index] <= 1'b0;
            r_beat           <= 2'd0;
            mem_req          <= 1'b1;
            mem_we           <= 1'b0;
            mem_be           <= 4'b0000;
            mem_addr         <= {addr_in[31:4], 4'b0000};
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) begin
              r_valid[w_index] <= 1'b1;
              mem_req          <= 1'b0;
            end else begin
              mem_addr <= {addr_in[31:4], r_beat + 2'd1, 2'b00};
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays; contents are qualified by r_valid so they need no reset.
  always_ff @(posedge CLK) begin
    if ((r_state == ST_IDLE) && !wr_in && rd_in && !w_hit) begin
      r_tag[w_index] <= w_tag;
    end
    if ((r_state == ST_FILL) && mem_ack) begin
      r_data[w_index][r_beat] <= mem_rdata;
    end
    if ((r_state == ST_WRITE) && mem_ack && w_hit) begin
      r_data[w_index][w_word] <= w_merged;
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_count   <= 32'h0000_0000;
      miss_count  <= 32'h0000_0000;
      write_count <= 32'h0000_0000;
    end else if (r_state == ST_IDLE) begin
      if (wr_in) begin
        if (write_count != 32'hFFFF_FFFF) write_count <= write_count + 32'd1;
      end else if (rd_in && w_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else if (rd_in) begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt against a memory/tag-array reference model.
module tb_dcache_wt;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] wdata_in = 32'h0;
  logic [1:0]  wsize_in = 2'd0;
  logic        rd_in = 1'b0;
  logic        wr_in = 1'b0;
  logic [31:0] rdata_out;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, write_count;
`endif

  dcache_wt dut (
    .CLK(CLK), .RESET(RESET), .addr_in(addr_in), .wdata_in(wdata_in),
    .wsize_in(wsize_in), .rd_in(rd_in), .wr_in(wr_in), .rdata_out(rdata_out),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .write_count(write_count)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  int unsigned mem_m [int unsigned];
  bit          m_valid [64];
  int unsigned m_tag [64];

  function automatic int unsigned memrd(int unsigned a);
    int unsigned w = a & 32'hFFFF_FFFC;
    if (mem_m.exists(w)) return mem_m[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bemask(logic [3:0] be);
    logic [31:0] m = 32'h0;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Source byte i of an n-byte store lands at byte offset+i (offset 0 = MSB), clipped at 3.
  task automatic exp_lanes(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] ws,
                           output logic [3:0] be, output logic [31:0] data);
    int n = (ws == 2'd0) ? 4 : int'(ws);
    be = 4'b0000;
    data = 32'h0;
    for (int i = 0; i < n; i++) begin
      int p = int'(a[1:0]) + i;
      if (p <= 3) begin
        be[3-p] = 1'b1;
        data[8*(3-p) +: 8] = 8'((wd >> (8*(n-1-i))) & 32'hFF);
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(bit rd, bit wr, logic [31:0] a, logic [31:0] wd, logic [1:0] ws);
    int          idx = int'((a >> 4) & 32'd63);
    int unsigned tg = a >> 10;
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    int          acks = 0;
    int          cyc = 0;
    bit          done = 1'b0;
    logic [31:0] got = 32'h0;
    logic [3:0]  ebe;
    logic [31:0] edata;
    exp_lanes(a, wd, ws, ebe, edata);
    @(negedge CLK);
    rd_in = rd; wr_in = wr; addr_in = a; wdata_in = wd; wsize_in = ws;
    while (!done) begin
      #1;
      if (!stall_out) begin
        done = 1'b1;
        got = rdata_out;
      end else if (cyc > 60) begin
        chk("timeout_cycles", 32'(cyc), 32'd0);
        done = 1'b1;
      end else begin
        if (mem_req && ($urandom_range(1, 0) == 1)) begin
          if (wr) begin
            chk("wr_we", {31'h0, mem_we}, 32'd1);
            chk("wr_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("wr_be", {28'h0, mem_be}, {28'h0, ebe});
            chk("wr_data", mem_wdata & bemask(ebe), edata);
          end else begin
            chk("fill_we", {31'h0, mem_we}, 32'd0);
            chk("fill_addr", mem_addr, (a & 32'hFFFF_FFF0) + 32'(4 * acks));
            mem_rdata = memrd((a & 32'hFFFF_FFF0) + 32'(4 * acks));
          end
          mem_ack = 1'b1;
          acks++;
        end
        @(negedge CLK);
        mem_ack = 1'b0;
        cyc++;
      end
    end
    if (wr) begin
      int unsigned w = a & 32'hFFFF_FFFC;
      chk("wr_acks", 32'(acks), 32'd1);
      mem_m[w] = (memrd(w) & ~bemask(ebe)) | edata;
    end else if (rd) begin
      if (hit) begin
        chk("hit_acks", 32'(acks), 32'd0);
        chk("hit_cycles", 32'(cyc), 32'd0);
      end else begin
        chk("miss_acks", 32'(acks), 32'd4);
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
      end
      chk("rdata", got, memrd(a));
    end else begin
      chk("idle_rdata", got, 32'h0);
    end
    chk("req_low", {31'h0, mem_req}, 32'd0);
  endtask

  initial begin
    int acks;
    logic [31:0] base;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    mem_m[32'h40] = 32'h1111_1111;
    mem_m[32'h44] = 32'h2222_2222;
    mem_m[32'h48] = 32'h3333_3333;
    mem_m[32'h4C] = 32'h4444_4444;

    #12;
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_we", {31'h0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'd0);
    chk("rst_rdata", rdata_out, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    run_op(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
    run_op(1'b1, 1'b0, 32'h48, 32'h0, 2'd0);
    run_op(1'b0, 1'b1, 32'h43, 32'h0000_00AB, 2'd1);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
    chk("sb_merge_model", memrd(32'h40), 32'h1111_11AB);
    run_op(1'b0, 1'b1, 32'h41, 32'h00CC_DDEE, 2'd3);
    run_op(1'b0, 1'b1, 32'h42, 32'h0000_1234, 2'd2);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
    run_op(1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 2'd0);
    run_op(1'b1, 1'b0, 32'h1000, 32'h0, 2'd0);
    run_op(1'b1, 1'b0, 32'h440, 32'h0, 2'd0);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);
    run_op(1'b1, 1'b1, 32'h44, 32'h0000_5566, 2'd2);
    run_op(1'b0, 1'b0, 32'h44, 32'h0, 2'd0);

    for (int n = 0; n < 200; n++) begin
      int unsigned r = $urandom_range(9, 0);
      logic [31:0] a = (32'($urandom_range(2, 0)) << 10) | (32'($urandom_range(6, 4)) << 4)
                     | (32'($urandom_range(3, 0)) << 2);
      if (r < 5) begin
        run_op(1'b1, 1'b0, a, 32'h0, 2'd0);
      end else if (r < 8) begin
        run_op(1'b0, 1'b1, a | 32'($urandom_range(3, 0)), $urandom, 2'($urandom_range(3, 0)));
      end else if (r < 9) begin
        run_op(1'b1, 1'b1, a | 32'($urandom_range(3, 0)), $urandom, 2'($urandom_range(3, 0)));
      end else begin
        run_op(1'b0, 1'b0, a, 32'h0, 2'd0);
      end
    end

    base = 32'h3F00_0200;
    @(negedge CLK);
    rd_in = 1'b1; wr_in = 1'b0; addr_in = base;
    acks = 0;
    for (int c = 0; (c < 60) && (acks < 2); c++) begin
      #1;
      if (mem_req && ($urandom_range(1, 0) == 1)) begin
        mem_rdata = memrd(base + 32'(4 * acks));
        mem_ack = 1'b1;
        acks++;
      end
      @(negedge CLK);
      mem_ack = 1'b0;
    end
    #1;
    chk("beat2_addr", mem_addr, base + 32'h8);
    chk("beat2_stall", {31'h0, stall_out}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("abort_req", {31'h0, mem_req}, 32'd0);
    chk("abort_stall", {31'h0, stall_out}, 32'd0);
    chk("abort_addr", mem_addr, 32'h0);
    rd_in = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    run_op(1'b1, 1'b0, base, 32'h0, 2'd0);
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
